// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: syncs rx_i, deserializes start/cmd/addr/data/parity/stop, flags errors.
// Frame is published one cycle after the stop-bit sample and held until valid&&ready; a frame completing while busy is dropped (overrun).
module serial_frame_rx #(
  parameter int CLK_DIV     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  output logic              frame_valid_o,
  input  logic              frame_ready_i,
  output logic [1:0]        cmd_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              parity_err_o,
  output logic              stop_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    STATE_IDLE, STATE_START, STATE_CMD, STATE_ADDR,
    STATE_DATA, STATE_PARITY, STATE_STOP, STATE_DONE
  } frame_state_e;

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;
  localparam logic [CW-1:0] HALF      = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] FULL      = CW'(CLK_DIV);
  localparam logic [BW-1:0] CMD_LAST  = BW'(1);
  localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_W - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

  frame_state_e state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   armed;
  logic [CW-1:0]          cyc_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [1:0]             cmd_sh;
  logic [ADDR_W-1:0]      addr_sh;
  logic [DATA_W-1:0]      data_sh;
  logic                   par_sh;
  logic                   tick, sample, field_end, publish;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign busy_o  = (state != STATE_IDLE);
  assign publish = (state == STATE_STOP) && sample;

  always_ff @(posedge clk) begin
    if (rst) state <= STATE_IDLE;
    else     state <= state_nxt;
  end

  // Start bit is checked at half a bit; every later bit one full bit period on.
  always_comb begin
    tick      = (state == STATE_START) ? (cyc_cnt == HALF) : (cyc_cnt == FULL);
    sample    = 1'b0;
    field_end = 1'b1;
    state_nxt = state;
    case (state)
      STATE_IDLE:   if (armed && !rx_s) state_nxt = STATE_START;
      STATE_START: begin
        sample = tick;
        if (tick) state_nxt = rx_s ? STATE_IDLE : STATE_CMD;
      end
      STATE_CMD: begin
        sample    = tick;
        field_end = (bit_cnt == CMD_LAST);
        if (tick && field_end) state_nxt = STATE_ADDR;
      end
      STATE_ADDR: begin
        sample    = tick;
        field_end = (bit_cnt == ADDR_LAST);
        if (tick && field_end) state_nxt = STATE_DATA;
      end
      STATE_DATA: begin
        sample    = tick;
        field_end = (bit_cnt == DATA_LAST);
        if (tick && field_end) state_nxt = STATE_PARITY;
      end
      STATE_PARITY: begin
        sample = tick;
        if (tick) state_nxt = STATE_STOP;
      end
      STATE_STOP: begin
        sample = tick;
        if (tick) state_nxt = STATE_DONE;
      end
      STATE_DONE:   state_nxt = STATE_IDLE;
      default:      state_nxt = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '1;
      armed         <= 1'b0;
      cyc_cnt       <= '0;
      bit_cnt       <= '0;
      cmd_sh        <= '0;
      addr_sh       <= '0;
      data_sh       <= '0;
      par_sh        <= 1'b0;
      frame_valid_o <= 1'b0;
      cmd_o         <= '0;
      addr_o        <= '0;
      data_o        <= '0;
      parity_err_o  <= 1'b0;
      stop_err_o    <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      overrun_o <= 1'b0;

      case (state)
        STATE_IDLE: begin
          cyc_cnt <= CW'(1);
          bit_cnt <= '0;
          if (rx_s)       armed <= 1'b1;
          else if (armed) armed <= 1'b0;
        end
        STATE_DONE: begin
          cyc_cnt <= CW'(1);
          bit_cnt <= '0;
          // A stuck-low line after a bad stop bit must not look like a new start.
          armed   <= rx_s;
        end
        default: begin
          cyc_cnt <= sample ? CW'(1) : cyc_cnt + 1'b1;
          if (sample && state != STATE_START)
            bit_cnt <= field_end ? '0 : bit_cnt + 1'b1;
        end
      endcase

      if (sample) begin
        case (state)
          STATE_CMD:    cmd_sh  <= {cmd_sh[0], rx_s};
          STATE_ADDR:   addr_sh <= {addr_sh[ADDR_W-2:0], rx_s};
          STATE_DATA:   data_sh <= {data_sh[DATA_W-2:0], rx_s};
          STATE_PARITY: par_sh  <= rx_s;
          default: ;
        endcase
      end

      if (frame_valid_o && frame_ready_i) frame_valid_o <= 1'b0;

      if (publish) begin
        if (!frame_valid_o || frame_ready_i) begin
          frame_valid_o <= 1'b1;
          cmd_o         <= cmd_sh;
          addr_o        <= addr_sh;
          data_o        <= data_sh;
          parity_err_o  <= par_sh ^ (^{cmd_sh, addr_sh, data_sh});
          stop_err_o    <= ~rx_s;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: hand-built frames, latency, error flags, overrun and reset.
module tb_serial_frame_rx;
  localparam int CLK_DIV = 4;
  localparam int LAT     = 109; // drive-edge of start bit to valid: 2 sync + 107

  logic        clk = 1'b0;
  logic        rst, rx_i, frame_ready_i;
  logic        frame_valid_o, parity_err_o, stop_err_o, overrun_o, busy_o;
  logic [1:0]  cmd_o;
  logic [13:0] addr_o;
  logic [7:0]  data_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rises    = 0;
  int ov_cnt   = 0;
  logic vld_prev = 1'b0;
  int lat, r0, o0, busy_seen;

  serial_frame_rx #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(2), .ADDR_W(14), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i),
    .frame_valid_o(frame_valid_o), .frame_ready_i(frame_ready_i),
    .cmd_o(cmd_o), .addr_o(addr_o), .data_o(data_o),
    .parity_err_o(parity_err_o), .stop_err_o(stop_err_o),
    .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid_o && !vld_prev) rises++;
    if (overrun_o) ov_cnt++;
    vld_prev = frame_valid_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of the 27-bit frame, start bit first.
  task automatic send_frame(input logic [1:0] c, input logic [13:0] a, input logic [7:0] d,
                            input logic p, input logic s, input int nbits);
    logic [26:0] f;
    f = {1'b0, c, a, d, p, s};
    start_cyc = cyc;
    for (int i = 26; i > 26 - nbits; i--) send_bit(f[i]);
  endtask

  task automatic wait_frame(output int l);
    l = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_valid_o) begin
        l = cyc - start_cyc;
        break;
      end
    end
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rx_i = 1'b1; frame_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(frame_valid_o), 32'h0);
    check("rst_busy",  32'(busy_o),        32'h0);
    check("rst_addr",  32'(addr_o),        32'h0);
    realign();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 1: clean frame
    send_frame(2'b01, 14'h1234, 8'hA5, 1'b0, 1'b1, 27);
    wait_frame(lat);
    check("t1_lat",  32'(lat),          32'(LAT));
    check("t1_cmd",  32'(cmd_o),        32'h1);
    check("t1_addr", 32'(addr_o),       32'h1234);
    check("t1_data", 32'(data_o),       32'hA5);
    check("t1_perr", 32'(parity_err_o), 32'h0);
    check("t1_serr", 32'(stop_err_o),   32'h0);
    realign();
    @(negedge clk);
    check("t1_one_cycle", 32'(frame_valid_o), 32'h0);
    realign();
    repeat (4) @(posedge clk);
    #1;

    // 2: bad parity still delivered
    send_frame(2'b01, 14'h1234, 8'hA5, 1'b1, 1'b1, 27);
    wait_frame(lat);
    check("t2_lat",  32'(lat),          32'(LAT));
    check("t2_perr", 32'(parity_err_o), 32'h1);
    check("t2_serr", 32'(stop_err_o),   32'h0);
    realign();

    // 3: stop error, line stuck low, then recovery
    r0 = rises;
    send_frame(2'b00, 14'h0, 8'h00, 1'b0, 1'b0, 27);
    wait_frame(lat);
    check("t3_lat",  32'(lat),          32'(LAT));
    check("t3_serr", 32'(stop_err_o),   32'h1);
    check("t3_perr", 32'(parity_err_o), 32'h0);
    realign();
    repeat (200) @(posedge clk);
    #1;
    check("t3_stuck_busy",   32'(busy_o),     32'h0);
    check("t3_stuck_frames", 32'(rises - r0), 32'h1);
    check("t3_no_overrun",   32'(ov_cnt),     32'h0);
    rx_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send_frame(2'b01, 14'h1234, 8'hA5, 1'b0, 1'b1, 27);
    wait_frame(lat);
    check("t3_rec_lat",  32'(lat),        32'(LAT));
    check("t3_rec_addr", 32'(addr_o),     32'h1234);
    check("t3_rec_serr", 32'(stop_err_o), 32'h0);
    realign();
    repeat (4) @(posedge clk);
    #1;

    // 4: short glitch
    r0 = rises;
    busy_seen = 0;
    rx_i = 1'b0;
    realign();
    rx_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy_o) busy_seen++;
    end
    check("t4_busy_seen", 32'(busy_seen),  32'h2);
    check("t4_busy_end",  32'(busy_o),     32'h0);
    check("t4_no_frame",  32'(rises - r0), 32'h0);
    realign();
    repeat (4) @(posedge clk);
    #1;

    // 5: back-to-back with consumer stalled
    frame_ready_i = 1'b0;
    r0 = rises;
    o0 = ov_cnt;
    send_frame(2'b10, 14'h0001, 8'h3C, 1'b0, 1'b1, 27);
    send_frame(2'b01, 14'h0002, 8'h5A, 1'b0, 1'b1, 27);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t5_valid",   32'(frame_valid_o), 32'h1);
    check("t5_addr",    32'(addr_o),        32'h0001);
    check("t5_cmd",     32'(cmd_o),         32'h2);
    check("t5_data",    32'(data_o),        32'h3C);
    check("t5_overrun", 32'(ov_cnt - o0),   32'h1);
    realign();
    frame_ready_i = 1'b1;
    realign();
    @(negedge clk);
    check("t5_consumed", 32'(frame_valid_o), 32'h0);
    realign();
    repeat (150) @(posedge clk);
    #1;
    check("t5_b_dropped", 32'(rises - r0), 32'h1);

    // 6: reset mid-address, then full frame
    send_frame(2'b10, 14'h1555, 8'h11, 1'b0, 1'b1, 12);
    @(negedge clk);
    check("t6_busy_pre", 32'(busy_o), 32'h1);
    realign();
    rst = 1'b1;
    rx_i = 1'b1;
    realign();
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy",  32'(busy_o),        32'h0);
    check("t6_valid", 32'(frame_valid_o), 32'h0);
    check("t6_cmd",   32'(cmd_o),         32'h0);
    check("t6_addr",  32'(addr_o),        32'h0);
    check("t6_data",  32'(data_o),        32'h0);
    realign();
    repeat (4) @(posedge clk);
    #1;
    send_frame(2'b11, 14'h3FFF, 8'hFF, 1'b0, 1'b1, 27);
    wait_frame(lat);
    check("t6_lat",  32'(lat),          32'(LAT));
    check("t6_cmd2", 32'(cmd_o),        32'h3);
    check("t6_addr2",32'(addr_o),       32'h3FFF);
    check("t6_data2",32'(data_o),       32'hFF);
    check("t6_perr", 32'(parity_err_o), 32'h0);
    realign();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
